// File: rtl/ifetch_if.sv
// Fetch-stage bundle: memory-controller req/done handshake plus the ID-facing queue head
// and the EX redirect inputs. The master modport is the fetch stage itself.
interface ifetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [INST_W-1:0] mem_inst_i;
    logic              mem_done_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              id_stall_i;
    logic              if_valid_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              if_pred_taken_o;
    logic              if_full_o;

    modport master (
        output mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o, if_pred_taken_o, if_full_o,
        input  mem_inst_i, mem_done_i, redirect_i, redirect_pc_i, id_stall_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o, if_pred_taken_o, if_full_o,
        output mem_inst_i, mem_done_i, redirect_i, redirect_pc_i, id_stall_i
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue, one request in flight, redirect flush.
// Optional JAL static prediction on push is enabled by defining IF_JAL_PRED_EN.
module ifetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    ifetch_if.master bus
);
    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INST_BYTES = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [ADDR_W-1:0] next_pc;
    logic              pop;
    logic              push;

`ifdef IF_JAL_PRED_EN
    logic              is_jal;
    logic [ADDR_W-1:0] jal_off;
    logic [DEPTH-1:0]  pred_mem_q, pred_mem_d;

    // JAL immediate is sign-extended from its 21-bit scrambled encoding
    always_comb begin
        is_jal  = (bus.mem_inst_i[6:0] == 7'b1101111);
        jal_off = ADDR_W'($signed({bus.mem_inst_i[31], bus.mem_inst_i[19:12], bus.mem_inst_i[20],
                                   bus.mem_inst_i[30:21], 1'b0}));
        next_pc = fetch_pc_q + (is_jal ? jal_off : INST_BYTES);
    end

    always_comb begin
        pred_mem_d = pred_mem_q;
        if (push) begin
            pred_mem_d[wr_ptr_q] = is_jal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_mem_q <= '0;
        end else if (rdy) begin
            pred_mem_q <= pred_mem_d;
        end
    end

    assign bus.if_pred_taken_o = pred_mem_q[rd_ptr_q];
`else
    assign next_pc             = fetch_pc_q + INST_BYTES;
    assign bus.if_pred_taken_o = 1'b0;
`endif

    // Fetch FSM and queue bookkeeping; redirect overrides both push and pop
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        inst_mem_d  = inst_mem_q;
        push        = 1'b0;
        pop         = (count_q != '0) && !bus.id_stall_i && !bus.redirect_i;

        unique case (state_q)
            IDLE: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = bus.redirect_pc_i;
                    state_d    = WAIT;
                end else if ((count_q < FULL_CNT) || pop) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = bus.redirect_pc_i;
                    if (!bus.mem_done_i) begin
                        // in-flight word must still be absorbed before the new fetch goes out
                        drop_addr_d = fetch_pc_q;
                        state_d     = DROP;
                    end
                end else if (bus.mem_done_i) begin
                    push       = 1'b1;
                    fetch_pc_d = next_pc;
                    if (!pop && (count_q == FULL_CNT - CNT_W'(1))) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = bus.redirect_pc_i;
                end
                if (bus.mem_done_i) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            pc_mem_d[wr_ptr_q]   = fetch_pc_q;
            inst_mem_d[wr_ptr_q] = bus.mem_inst_i;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (bus.redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pc_mem_q    <= '{default: '0};
            inst_mem_q  <= '{default: '0};
        end else if (rdy) begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            inst_mem_q  <= inst_mem_d;
        end
    end

    assign bus.mem_req_o  = (state_q != IDLE);
    assign bus.mem_addr_o = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign bus.if_valid_o = (count_q != '0);
    assign bus.if_full_o  = (count_q == FULL_CNT);
    assign bus.if_pc_o    = pc_mem_q[rd_ptr_q];
    assign bus.if_inst_o  = inst_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written corner sequences, and a long
// random run checked against a transaction-level queue model with an in-bench memory responder.
`timescale 1ns/1ps
module tb_ifetch_queue;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    ifetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    ifetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: queue of fetched entries ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch;   // address of the next fetch to be issued
    logic [31:0] m_infl;    // address of the request currently on the bus
    bit          m_out;     // a request is outstanding
    bit          m_disc;    // the outstanding response will be thrown away

    // returns {pred, next_pc}
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] inst);
        int unsigned off;
`ifdef IF_JAL_PRED_EN
        if (inst[6:0] == 7'h6F) begin
            off = (32'(inst[30:21]) << 1) + (32'(inst[20]) << 11) + (32'(inst[19:12]) << 12);
            if (inst[31]) off = off - 32'h0010_0000;
            return {1'b1, pc + off};
        end
`endif
        off = 32'd4;
        return {1'b0, pc + off};
    endfunction

    task automatic model_edge(input bit r, input bit stall, input bit redir, input logic [31:0] rpc,
                              input bit done, input logic [31:0] inst);
        bit          pop;
        logic [32:0] pn;
        if (!r) return;
        pop = (mq.size() > 0) && !stall && !redir;
        if (redir) begin
            mq.delete();
            m_fetch = rpc;
            if (m_out && !done) m_disc = 1'b1;
            else begin
                m_out  = 1'b1;
                m_disc = 1'b0;
                m_infl = rpc;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_out && done) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                    m_infl = m_fetch;
                end else begin
                    pn = predict(m_fetch, inst);
                    mq.push_back('{pc: m_fetch, inst: inst, pred: pn[32]});
                    m_fetch = pn[31:0];
                    if (mq.size() < DEPTH) m_infl = m_fetch;
                    else m_out = 1'b0;
                end
            end else if (!m_out && mq.size() < DEPTH) begin
                m_out  = 1'b1;
                m_infl = m_fetch;
            end
        end
    endtask

    task automatic model_check();
        chk("mem_req", 32'(bus.mem_req_o), 32'(m_out));
        chk("mem_addr", bus.mem_addr_o, m_out ? m_infl : m_fetch);
        chk("if_valid", 32'(bus.if_valid_o), 32'(mq.size() > 0));
        chk("if_full", 32'(bus.if_full_o), 32'(mq.size() == DEPTH));
        if (mq.size() > 0) begin
            chk("if_pc", bus.if_pc_o, mq[0].pc);
            chk("if_inst", bus.if_inst_o, mq[0].inst);
            chk("if_pred", 32'(bus.if_pred_taken_o), 32'(mq[0].pred));
        end
    endtask

    // ---------------- memory responder / stepping ----------------
    bit          r_busy;
    int          r_cnt;
    logic [31:0] r_addr;
    int          n_req;
    int          lat_min = 2;
    int          lat_max = 2;
    logic [31:0] popped[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic step_raw(input bit r, input bit stall, input bit redir, input logic [31:0] rpc,
                            input bit done, input logic [31:0] inst);
        rdy               = r;
        bus.id_stall_i    = stall;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.mem_done_i    = done;
        bus.mem_inst_i    = inst;
        if (r && bus.if_valid_o && !stall && !redir) popped.push_back(bus.if_pc_o);
        @(posedge clk);
        model_edge(r, stall, redir, rpc, done, inst);
        @(negedge clk);
        model_check();
    endtask

    task automatic step_auto(input bit r, input bit stall, input bit redir, input logic [31:0] rpc,
                             input bit jal_mix);
        bit          done;
        logic [31:0] inst;
        done = 1'b0;
        inst = '0;
        if (!r_busy && bus.mem_req_o) begin
            r_busy = 1'b1;
            r_cnt  = $urandom_range(lat_max, lat_min);
            r_addr = bus.mem_addr_o;
            n_req++;
        end
        if (r_busy && r) begin
            if (r_cnt <= 1) begin
                done   = 1'b1;
                r_busy = 1'b0;
                inst   = word_at(r_addr);
                if (jal_mix && $urandom_range(7, 0) == 0) inst = {$urandom() & 32'hFFFF_FF80} | 32'h6F;
            end else r_cnt--;
        end
        step_raw(r, stall, redir, rpc, done, inst);
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        rdy               = 1'b1;
        bus.id_stall_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.mem_done_i    = 1'b0;
        bus.mem_inst_i    = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid_o), 32'h0);
        chk("rst_if_pc", bus.if_pc_o, 32'h0);
        chk("rst_if_inst", bus.if_inst_o, 32'h0);
        chk("rst_if_pred", 32'(bus.if_pred_taken_o), 32'h0);
        chk("rst_if_full", 32'(bus.if_full_o), 32'h0);
        mq.delete();
        popped.delete();
        m_fetch = '0;
        m_infl  = '0;
        m_out   = 1'b0;
        m_disc  = 1'b0;
        r_busy  = 1'b0;
        n_req   = 0;
        rst     = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r, stall, redir;
        logic [31:0] rpc;
        bit          done;
        logic [31:0] inst;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_full;
    } vec_t;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    initial begin
        vec_t tbl[18];
        tbl[0]  = '{T, T, F, 32'h0,   F, 32'h0,           T, 32'h0,   F, 32'h0,   F};
        tbl[1]  = '{T, T, F, 32'h0,   T, word_at(32'h0),  T, 32'h4,   T, 32'h0,   F};
        tbl[2]  = '{T, T, F, 32'h0,   F, 32'h0,           T, 32'h4,   T, 32'h0,   F};
        tbl[3]  = '{T, T, F, 32'h0,   T, word_at(32'h4),  T, 32'h8,   T, 32'h0,   F};
        tbl[4]  = '{T, T, F, 32'h0,   T, word_at(32'h8),  T, 32'hC,   T, 32'h0,   F};
        tbl[5]  = '{T, T, F, 32'h0,   T, word_at(32'hC),  F, 32'h10,  T, 32'h0,   T};
        tbl[6]  = '{T, T, F, 32'h0,   F, 32'h0,           F, 32'h10,  T, 32'h0,   T};
        tbl[7]  = '{T, F, F, 32'h0,   F, 32'h0,           T, 32'h10,  T, 32'h4,   F};
        tbl[8]  = '{T, T, T, 32'h100, F, 32'h0,           T, 32'h10,  F, 32'h0,   F};
        tbl[9]  = '{T, F, F, 32'h0,   T, word_at(32'h10), T, 32'h100, F, 32'h0,   F};
        tbl[10] = '{T, F, F, 32'h0,   T, word_at(32'h100),T, 32'h104, T, 32'h100, F};
        tbl[11] = '{T, F, T, 32'h200, T, word_at(32'h104),T, 32'h200, F, 32'h0,   F};
        tbl[12] = '{F, F, T, 32'h300, F, 32'h0,           T, 32'h200, F, 32'h0,   F};
        tbl[13] = '{T, T, F, 32'h0,   T, word_at(32'h200),T, 32'h204, T, 32'h200, F};
        tbl[14] = '{T, F, F, 32'h0,   F, 32'h0,           T, 32'h204, F, 32'h0,   F};
        tbl[15] = '{T, F, T, 32'h400, F, 32'h0,           T, 32'h204, F, 32'h0,   F};
        tbl[16] = '{T, F, T, 32'h500, F, 32'h0,           T, 32'h204, F, 32'h0,   F};
        tbl[17] = '{T, F, F, 32'h0,   T, word_at(32'h204),T, 32'h500, F, 32'h0,   F};

        do_reset();
        foreach (tbl[i]) begin
            step_raw(tbl[i].r, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].done, tbl[i].inst);
            chk($sformatf("tbl%0d_req", i), 32'(bus.mem_req_o), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), bus.mem_addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.if_valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_full", i), 32'(bus.if_full_o), 32'(tbl[i].e_full));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), bus.if_pc_o, tbl[i].e_pc);
        end

        // streaming with 2-cycle memory and no stall: in-order PCs, one word every 2 cycles
        do_reset();
        lat_min = 2;
        lat_max = 2;
        step_auto(T, F, F, 32'h0, F);
        chk("first_req", 32'(bus.mem_req_o), 32'h1);
        repeat (15) step_auto(T, F, F, 32'h0, F);
        chk("stream_pops", 32'(popped.size() >= 6), 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (i < popped.size()) chk($sformatf("stream_pc%0d", i), popped[i], 32'(4 * i));
            else chk($sformatf("stream_pc%0d", i), 32'hFFFF_FFFF, 32'(4 * i));
        end

        // ID stalled: queue fills with exactly DEPTH fetches, then one pop releases one fetch
        do_reset();
        repeat (20) step_auto(T, T, F, 32'h0, F);
        chk("fill_nreq", 32'(n_req), 32'(DEPTH));
        chk("fill_full", 32'(bus.if_full_o), 32'h1);
        chk("fill_req", 32'(bus.mem_req_o), 32'h0);
        step_auto(T, F, F, 32'h0, F);
        chk("release_full", 32'(bus.if_full_o), 32'h0);
        chk("release_req", 32'(bus.mem_req_o), 32'h1);
        chk("release_addr", bus.mem_addr_o, 32'h10);
        chk("release_pc", bus.if_pc_o, 32'h4);
        repeat (6) step_auto(T, T, F, 32'h0, F);
        chk("refill_nreq", 32'(n_req), 32'(DEPTH + 1));

        // rdy low for 5 cycles mid-stream, with stall/redirect noise that must be ignored
        do_reset();
        lat_min = 1;
        lat_max = 3;
        repeat (9) step_auto(T, ($urandom_range(2, 0) == 0), F, 32'h0, F);
        for (int i = 0; i < 5; i++) begin
            step_auto(F, i[0], (i == 2), 32'h0000_0800, F);
            chk($sformatf("freeze%0d_addr", i), bus.mem_addr_o, m_out ? m_infl : m_fetch);
        end
        repeat (10) step_auto(T, F, F, 32'h0, F);

        // JAL at address 0
        do_reset();
        step_raw(T, T, F, 32'h0, F, 32'h0);
        step_raw(T, T, F, 32'h0, T, 32'h0100_006F);
        chk("jal_pc", bus.if_pc_o, 32'h0);
`ifdef IF_JAL_PRED_EN
        chk("jal_pred", 32'(bus.if_pred_taken_o), 32'h1);
        chk("jal_next", bus.mem_addr_o, 32'h10);
`else
        chk("jal_pred", 32'(bus.if_pred_taken_o), 32'h0);
        chk("jal_next", bus.mem_addr_o, 32'h4);
`endif

        // long random run, including redirects near the top of memory
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            bit          r, st, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(99, 0) < 85);
            st  = ($urandom_range(99, 0) < 40);
            rd  = ($urandom_range(99, 0) < 4);
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                              : ($urandom() & 32'h000F_FFFC);
            step_auto(r, st, rd, rpc, T);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
